lab4_lut_engine: RTL and testbench

//  Programmable N-input boolean function engine: evaluates a stored 2**N_IN-entry

---
 rtl/lab4_lut_engine.sv | 92 +++++++++
 tb/tb_lab4_lut_engine.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lab4_lut_engine.sv
// lab4_lut_engine: programmable N-input truth-table evaluator with serial table reload and saturating hit counter
//   CL2947MP_clk/rst                 clock, async active-high reset
//   CL2947MP_in_valid/in_vec         evaluation request and input vector
//   CL2947MP_out_valid/out_f         registered result (latency 1+PIPE)
//   CL2947MP_cfg_start/valid/bit     serial table load, index 0 first
//   CL2947MP_cfg_busy/cfg_done       load in progress / new table committed pulse
//   CL2947MP_cnt_clr/hit_cnt         hit counter clear / saturating count of 1 results
module lab4_lut_engine #(
  parameter int N_IN = 4,
  parameter logic [2**N_IN-1:0] RESET_TABLE = 16'hC0F7,
  parameter int PIPE = 0,
  parameter int CNT_W = 8
) (
  input  logic             CL2947MP_clk,
  input  logic             CL2947MP_rst,
  input  logic             CL2947MP_in_valid,
  input  logic [N_IN-1:0]  CL2947MP_in_vec,
  output logic             CL2947MP_out_valid,
  output logic             CL2947MP_out_f,
  input  logic             CL2947MP_cfg_start,
  input  logic             CL2947MP_cfg_valid,
  input  logic             CL2947MP_cfg_bit,
  output logic             CL2947MP_cfg_busy,
  output logic             CL2947MP_cfg_done,
  input  logic             CL2947MP_cnt_clr,
  output logic [CNT_W-1:0] CL2947MP_hit_cnt
);
  localparam int T = 2**N_IN;
  typedef enum logic [1:0] {RUN, LOAD, COMMIT} state_t;
  state_t state, state_nx;
  logic [T-1:0] tbl, shadow;
  logic [N_IN-1:0] bit_cnt;
  logic v1, f1;
  logic last_bit;
  assign last_bit = CL2947MP_cfg_valid && (&bit_cnt);
  always_ff @(posedge CL2947MP_clk or posedge CL2947MP_rst)
    if (CL2947MP_rst) state <= RUN;
    else state <= state_nx;
  // A start pulse inside LOAD restarts the load and masks that cycle's bit.
  always_comb
    state_nx = state == RUN  ? (CL2947MP_cfg_start ? LOAD : RUN) :
               state == LOAD ? (CL2947MP_cfg_start ? LOAD : last_bit ? COMMIT : LOAD) :
               RUN;
  always_comb begin
    CL2947MP_cfg_busy = state == LOAD;
    CL2947MP_cfg_done = state == COMMIT;
  end
  // The table swaps at the edge closing COMMIT, so the COMMIT-cycle input still sees the old table.
  always_ff @(posedge CL2947MP_clk or posedge CL2947MP_rst)
    if (CL2947MP_rst) begin
      tbl     <= RESET_TABLE;
      shadow  <= '0;
      bit_cnt <= '0;
    end else if (state == COMMIT) begin
      tbl <= shadow;
    end else if (CL2947MP_cfg_start) begin
      shadow  <= '0;
      bit_cnt <= '0;
    end else if (state == LOAD && CL2947MP_cfg_valid) begin
      shadow[bit_cnt] <= CL2947MP_cfg_bit;
      bit_cnt         <= bit_cnt + 1'b1;
    end
  always_ff @(posedge CL2947MP_clk or posedge CL2947MP_rst)
    if (CL2947MP_rst) begin
      v1 <= 1'b0;
      f1 <= 1'b0;
    end else begin
      v1 <= CL2947MP_in_valid;
      if (CL2947MP_in_valid) f1 <= tbl[CL2947MP_in_vec];
    end
  if (PIPE != 0) begin : g_pipe
    logic v2, f2;
    always_ff @(posedge CL2947MP_clk or posedge CL2947MP_rst)
      if (CL2947MP_rst) begin
        v2 <= 1'b0;
        f2 <= 1'b0;
      end else begin
        v2 <= v1;
        f2 <= f1;
      end
    assign CL2947MP_out_valid = v2;
    assign CL2947MP_out_f     = f2;
  end else begin : g_direct
    assign CL2947MP_out_valid = v1;
    assign CL2947MP_out_f     = f1;
  end
  always_ff @(posedge CL2947MP_clk or posedge CL2947MP_rst)
    if (CL2947MP_rst) CL2947MP_hit_cnt <= '0;
    else if (CL2947MP_cnt_clr) CL2947MP_hit_cnt <= '0;
    else if (CL2947MP_out_valid && CL2947MP_out_f && !(&CL2947MP_hit_cnt))
      CL2947MP_hit_cnt <= CL2947MP_hit_cnt + 1'b1;
endmodule

// File: tb/tb_lab4_lut_engine.sv
// tb_lab4_lut_engine: randomized self-checking bench for three lab4_lut_engine variants sharing one stimulus
module tb_lab4_lut_engine;
  logic clk = 0, rst = 0, in_valid = 0, cfg_start = 0, cfg_valid = 0, cfg_bit = 0, cnt_clr = 0;
  logic [3:0] in_vec = 0;
  logic ov_a, of_a, busy_a, done_a, ov_b, of_b, busy_b, done_b, ov_c, of_c, busy_c, done_c;
  logic [7:0] hit_a, hit_c;
  logic [2:0] hit_b;
  int pass_cnt = 0, chk_cnt = 0, done_seen = 0, ev_mode = 0;
  logic [15:0] m_tbl, m_sh;
  int m_mode, m_idx, mh_a, mh_b, mh_c;
  logic mv1, mf1, mv2, mf2;
  logic [15:0] seq_a, seq_c;
  logic [15:0] rt = 16'hC0F7;
  logic [15:0] lv;

  always #5 clk = ~clk;

  lab4_lut_engine u_a (
    .CL2947MP_clk(clk), .CL2947MP_rst(rst), .CL2947MP_in_valid(in_valid), .CL2947MP_in_vec(in_vec),
    .CL2947MP_out_valid(ov_a), .CL2947MP_out_f(of_a), .CL2947MP_cfg_start(cfg_start),
    .CL2947MP_cfg_valid(cfg_valid), .CL2947MP_cfg_bit(cfg_bit), .CL2947MP_cfg_busy(busy_a),
    .CL2947MP_cfg_done(done_a), .CL2947MP_cnt_clr(cnt_clr), .CL2947MP_hit_cnt(hit_a));
  lab4_lut_engine #(.CNT_W(3)) u_b (
    .CL2947MP_clk(clk), .CL2947MP_rst(rst), .CL2947MP_in_valid(in_valid), .CL2947MP_in_vec(in_vec),
    .CL2947MP_out_valid(ov_b), .CL2947MP_out_f(of_b), .CL2947MP_cfg_start(cfg_start),
    .CL2947MP_cfg_valid(cfg_valid), .CL2947MP_cfg_bit(cfg_bit), .CL2947MP_cfg_busy(busy_b),
    .CL2947MP_cfg_done(done_b), .CL2947MP_cnt_clr(cnt_clr), .CL2947MP_hit_cnt(hit_b));
  lab4_lut_engine #(.PIPE(1)) u_c (
    .CL2947MP_clk(clk), .CL2947MP_rst(rst), .CL2947MP_in_valid(in_valid), .CL2947MP_in_vec(in_vec),
    .CL2947MP_out_valid(ov_c), .CL2947MP_out_f(of_c), .CL2947MP_cfg_start(cfg_start),
    .CL2947MP_cfg_valid(cfg_valid), .CL2947MP_cfg_bit(cfg_bit), .CL2947MP_cfg_busy(busy_c),
    .CL2947MP_cfg_done(done_c), .CL2947MP_cnt_clr(cnt_clr), .CL2947MP_hit_cnt(hit_c));

  task automatic chk(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_all();
    chk("a_valid", ov_a, mv1);
    chk("a_f", of_a, mf1);
    chk("a_busy", busy_a, m_mode == 1);
    chk("a_done", done_a, m_mode == 2);
    chk("a_hit", hit_a, mh_a);
    chk("b_valid", ov_b, mv1);
    chk("b_f", of_b, mf1);
    chk("b_hit", hit_b, mh_b);
    chk("c_valid", ov_c, mv2);
    chk("c_f", of_c, mf2);
    chk("c_busy", busy_c, m_mode == 1);
    chk("c_done", done_c, m_mode == 2);
    chk("c_hit", hit_c, mh_c);
  endtask

  task automatic model_reset();
    m_tbl = 16'hC0F7; m_sh = 0; m_mode = 0; m_idx = 0;
    mv1 = 0; mf1 = 0; mv2 = 0; mf2 = 0; mh_a = 0; mh_b = 0; mh_c = 0;
  endtask

  task automatic step(input logic iv, input logic [3:0] vec, input logic cs, input logic cv,
                      input logic cb, input logic clr);
    in_valid = iv; in_vec = vec; cfg_start = cs; cfg_valid = cv; cfg_bit = cb; cnt_clr = clr;
    @(posedge clk);
    if (clr) begin
      mh_a = 0; mh_b = 0; mh_c = 0;
    end else begin
      if (mv1 && mf1) begin
        mh_a = mh_a < 255 ? mh_a + 1 : mh_a;
        mh_b = mh_b < 7 ? mh_b + 1 : mh_b;
      end
      if (mv2 && mf2) mh_c = mh_c < 255 ? mh_c + 1 : mh_c;
    end
    mv2 = mv1; mf2 = mf1;
    mv1 = iv;
    if (iv) mf1 = m_tbl[vec];
    if (m_mode == 2) begin
      m_tbl = m_sh; m_mode = 0;
    end else if (m_mode == 1) begin
      if (cs) begin
        m_idx = 0; m_sh = 0;
      end else if (cv) begin
        m_sh[m_idx] = cb;
        if (m_idx == 15) m_mode = 2;
        m_idx++;
      end
    end else if (cs) begin
      m_mode = 1; m_idx = 0; m_sh = 0;
    end
    #1;
    if (done_a) done_seen++;
    check_all();
  endtask

  task automatic cstep(input logic cs, input logic cv, input logic cb);
    if (ev_mode == 1) step(1'b1, 4'd0, cs, cv, cb, 1'b0);
    else step(1'($urandom), 4'($urandom), cs, cv, cb, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 0;
    check_all();
  endtask

  task automatic load(input logic [15:0] val, input int pre);
    lv = val;
    if (pre > 0) begin
      cstep(1, 0, 0);
      for (int k = 0; k < pre; k++) cstep(0, 1, 1'($urandom));
    end
    cstep(1, 0, 0);
    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, 2)) cstep(0, 0, 1'($urandom));
      cstep(0, 1, lv[k]);
    end
    chk("done_after_last_bit", done_a, 1);
  endtask

  task automatic sweep();
    for (int i = 0; i < 18; i++) begin
      step(i < 16, 4'(i), 0, 0, 0, 0);
      if (i < 16) seq_a[i] = of_a;
      if (i >= 1 && i <= 16) seq_c[i-1] = of_c;
      if (i == 16) chk("sweep_hit_a", hit_a, 9);
      if (i == 17) chk("sweep_hit_c", hit_c, 9);
    end
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("sweep_a[%0d]", i), seq_a[i], rt[i]);
      chk($sformatf("sweep_c[%0d]", i), seq_c[i], rt[i]);
    end
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();
    chk("reset_hit", hit_a, 0);
    sweep();
    chk("hit_b_saturated", hit_b, 7);
    step(1, 4'd0, 0, 0, 0, 0);
    step(1, 4'd0, 0, 0, 0, 1);
    chk("clr_prio_a", hit_a, 0);
    chk("clr_prio_b", hit_b, 0);
    load(16'h8000, 0);
    cstep(0, 0, 0);
    step(1, 4'd15, 0, 0, 0, 0);
    chk("t8000_f15", of_a, 1);
    step(1, 4'd0, 0, 0, 0, 0);
    chk("t8000_f0", of_a, 0);
    do_reset();
    ev_mode = 1;
    load(16'h0001, 0);
    cstep(0, 0, 0);
    chk("t0001_commit_in", of_a, 1);
    repeat (3) cstep(0, 0, 0);
    load(16'h0000, 0);
    cstep(0, 0, 0);
    chk("t0000_commit_in_old", of_a, 1);
    cstep(0, 0, 0);
    chk("t0000_after_commit", of_a, 0);
    ev_mode = 0;
    done_seen = 0;
    load(16'hFFFF, 7);
    repeat (4) cstep(0, 0, 0);
    chk("restart_one_done", done_seen, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 4'($urandom), 0, 0, 0, 0);
      chk("tffff_f", of_a, 1);
    end
    for (int i = 0; i < 500; i++)
      step(1'($urandom), 4'($urandom), ($urandom % 40) == 0, 1'($urandom), 1'($urandom),
           ($urandom % 50) == 0);
    cstep(1, 0, 0);
    for (int k = 0; k < 5; k++) cstep(0, 1, 1'($urandom));
    chk("busy_before_rst", busy_a, 1);
    do_reset();
    chk("busy_after_rst", busy_a, 0);
    sweep();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
